// File: rtl/uart_hram_cmd.sv
// ============================================================================
// Module   : uart_hram_cmd
// Brief    : Frames 5-byte UART commands onto hyper_xface, answers with 4 bytes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_hram_cmd #(
  parameter int unsigned RX_TIMEOUT = 96000,
  parameter int unsigned HR_TIMEOUT = 1024,
  parameter logic [31:0] CONST_VAL  = 32'd259
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rcv,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic [31:0] hr_addr,
  output logic [31:0] hr_wr_d,
  output logic        hr_wr_req,
  output logic        hr_rd_req,
  input  logic        hr_busy,
  input  logic        hr_rd_rdy,
  input  logic [31:0] hr_rd_d,
  output logic        err_overrun,
  output logic        err_timeout
);

  typedef enum logic [3:0] {
    S_RX       = 4'd0,
    S_DECODE   = 4'd1,
    S_HR_IDLE  = 4'd2,
    S_HR_REQ   = 4'd3,
    S_HR_WAIT  = 4'd4,
    S_TX_LOAD  = 4'd5,
    S_TX_SEND  = 4'd6,
    S_TX_WLOW  = 4'd7,
    S_TX_WHIGH = 4'd8
  } state_t;

  localparam logic [7:0] C_CMD_ADDR  = 8'h01;
  localparam logic [7:0] C_CMD_LOAD  = 8'h02;
  localparam logic [7:0] C_CMD_WRITE = 8'h03;
  localparam logic [7:0] C_CMD_READ  = 8'h04;
  localparam logic [7:0] C_CMD_RDREQ = 8'h05;
  localparam logic [7:0] C_CMD_COUNT = 8'h06;
  localparam logic [7:0] C_CMD_CONST = 8'h07;

  state_t      state_q;
  logic [39:0] frame_q;
  logic [2:0]  cnt_q;
  logic [31:0] idle_q;
  logic [31:0] to_q;
  logic        op_wr_q;
  logic        busy_seen_q;
  logic [31:0] resp_q;
  logic [1:0]  idx_q;
  logic [31:0] count_q;
  logic [31:0] rd_latch_q;
  logic        tx_start_q;
  logic [7:0]  tx_data_q;
  logic [31:0] hr_addr_q;
  logic [31:0] hr_wr_d_q;
  logic        hr_wr_req_q;
  logic        hr_rd_req_q;
  logic        err_overrun_q;
  logic        err_timeout_q;

  logic [7:0]  tx_byte_d;
  logic        hr_done_d;

  always_comb begin
    tx_byte_d = resp_q[31:24];
    case (idx_q)
      2'd0: tx_byte_d = resp_q[31:24];
      2'd1: tx_byte_d = resp_q[23:16];
      2'd2: tx_byte_d = resp_q[15:8];
      2'd3: tx_byte_d = resp_q[7:0];
      default: tx_byte_d = resp_q[31:24];
    endcase
  end

  // A write completes on the falling edge of busy, so busy must be seen high first.
  assign hr_done_d = op_wr_q ? (busy_seen_q && !hr_busy) : hr_rd_rdy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_RX;
      frame_q       <= '0;
      cnt_q         <= '0;
      idle_q        <= '0;
      to_q          <= '0;
      op_wr_q       <= 1'b0;
      busy_seen_q   <= 1'b0;
      resp_q        <= '0;
      idx_q         <= '0;
      count_q       <= '0;
      rd_latch_q    <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      hr_addr_q     <= '0;
      hr_wr_d_q     <= '0;
      hr_wr_req_q   <= 1'b0;
      hr_rd_req_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      hr_wr_req_q <= 1'b0;
      hr_rd_req_q <= 1'b0;
      tx_start_q  <= 1'b0;

      if (rcv && (state_q != S_RX)) begin
        err_overrun_q <= 1'b1;
      end

      case (state_q)
        S_RX: begin
          if (rcv) begin
            frame_q <= {frame_q[31:0], rx_data};
            idle_q  <= '0;
            if (cnt_q == 3'd4) begin
              cnt_q   <= '0;
              state_q <= S_DECODE;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end else if (cnt_q != 3'd0) begin
            if (idle_q == RX_TIMEOUT - 1) begin
              cnt_q  <= '0;
              idle_q <= '0;
            end else begin
              idle_q <= idle_q + 32'd1;
            end
          end
        end

        S_DECODE: begin
          state_q <= S_TX_LOAD;
          case (frame_q[39:32])
            C_CMD_ADDR: begin
              hr_addr_q <= frame_q[31:0];
              resp_q    <= frame_q[31:0];
            end
            C_CMD_LOAD: begin
              hr_wr_d_q <= frame_q[31:0];
              resp_q    <= frame_q[31:0];
            end
            C_CMD_WRITE: begin
              op_wr_q <= 1'b1;
              state_q <= S_HR_IDLE;
            end
            C_CMD_READ:  resp_q <= rd_latch_q;
            C_CMD_RDREQ: begin
              op_wr_q <= 1'b0;
              state_q <= S_HR_IDLE;
            end
            C_CMD_COUNT: begin
              resp_q  <= count_q;
              count_q <= count_q + 32'd1;
            end
            C_CMD_CONST: resp_q <= CONST_VAL;
            default:     resp_q <= 32'hFFFF_FFFF;
          endcase
        end

        S_HR_IDLE: begin
          if (!hr_busy) begin
            state_q <= S_HR_REQ;
            if (op_wr_q) begin
              hr_wr_req_q <= 1'b1;
            end else begin
              hr_rd_req_q <= 1'b1;
            end
          end
        end

        S_HR_REQ: begin
          to_q        <= '0;
          busy_seen_q <= 1'b0;
          state_q     <= S_HR_WAIT;
        end

        S_HR_WAIT: begin
          if (hr_done_d) begin
            state_q <= S_TX_LOAD;
            if (op_wr_q) begin
              resp_q <= 32'h0000_0003;
            end else begin
              resp_q     <= hr_rd_d;
              rd_latch_q <= hr_rd_d;
            end
          end else if (to_q == HR_TIMEOUT - 1) begin
            err_timeout_q <= 1'b1;
            resp_q        <= 32'hDEAD_BEEF;
            state_q       <= S_TX_LOAD;
          end else begin
            to_q <= to_q + 32'd1;
            if (hr_busy) begin
              busy_seen_q <= 1'b1;
            end
          end
        end

        S_TX_LOAD: begin
          idx_q   <= '0;
          state_q <= S_TX_SEND;
        end

        S_TX_SEND: begin
          if (tx_ready) begin
            tx_data_q  <= tx_byte_d;
            tx_start_q <= 1'b1;
            state_q    <= S_TX_WLOW;
          end
        end

        S_TX_WLOW: begin
          if (!tx_ready) begin
            state_q <= S_TX_WHIGH;
          end
        end

        S_TX_WHIGH: begin
          if (tx_ready) begin
            if (idx_q == 2'd3) begin
              cnt_q   <= '0;
              idle_q  <= '0;
              state_q <= S_RX;
            end else begin
              idx_q   <= idx_q + 2'd1;
              state_q <= S_TX_SEND;
            end
          end
        end

        default: state_q <= S_RX;
      endcase
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign hr_addr     = hr_addr_q;
  assign hr_wr_d     = hr_wr_d_q;
  assign hr_wr_req   = hr_wr_req_q;
  assign hr_rd_req   = hr_rd_req_q;
  assign err_overrun = err_overrun_q;
  assign err_timeout = err_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_hram_cmd.sv
// ============================================================================
// Module   : tb_uart_hram_cmd
// Brief    : Scoreboard bench for uart_hram_cmd with uart_tx and memory models.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_hram_cmd;

  localparam int unsigned RXT = 200;
  localparam int unsigned HRT = 64;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rcv = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        tx_ready = 1'b1;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [31:0] hr_addr;
  logic [31:0] hr_wr_d;
  logic        hr_wr_req;
  logic        hr_rd_req;
  logic        hr_busy = 1'b0;
  logic        hr_rd_rdy = 1'b0;
  logic [31:0] hr_rd_d = '0;
  logic        err_overrun;
  logic        err_timeout;

  int total = 0;
  int bad = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  bit rd_en = 1'b0;
  int rd_delay = 30;
  logic [31:0] rd_val = '0;
  logic [7:0] exp_q[$];

  uart_hram_cmd #(.RX_TIMEOUT(RXT), .HR_TIMEOUT(HRT), .CONST_VAL(32'd259)) dut (
    .clk(clk), .rstn(rstn), .rcv(rcv), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
    .hr_addr(hr_addr), .hr_wr_d(hr_wr_d), .hr_wr_req(hr_wr_req), .hr_rd_req(hr_rd_req),
    .hr_busy(hr_busy), .hr_rd_rdy(hr_rd_rdy), .hr_rd_d(hr_rd_d),
    .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // uart_tx: capture each started byte, drop ready one cycle later for three cycles
  initial begin : uart_tx_model
    logic [7:0] exp_b;
    forever begin
      @(posedge clk); #1;
      if (tx_start) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL tx_unexpected: got %02h, no byte expected", tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (tx_data !== exp_b) begin
            bad++;
            $display("FAIL tx_byte: got %02h, expected %02h", tx_data, exp_b);
          end
        end
        @(posedge clk); #1 tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
    end
  end

  // hyper_xface: write -> busy high 20 cycles starting 2 cycles later; read -> rd_rdy after rd_delay
  initial begin : mem_model
    forever begin
      @(posedge clk); #1;
      if (hr_wr_req) begin
        wr_pulses++;
        repeat (1) @(posedge clk);
        #1 hr_busy = 1'b1;
        repeat (20) @(posedge clk);
        #1 hr_busy = 1'b0;
      end else if (hr_rd_req) begin
        rd_pulses++;
        if (rd_en) begin
          repeat (rd_delay - 1) @(posedge clk);
          #1 hr_rd_rdy = 1'b1;
          hr_rd_d = rd_val;
          @(posedge clk);
          #1 hr_rd_rdy = 1'b0;
          hr_rd_d = '0;
        end
      end
    end
  end

  initial begin : protocol_monitor
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (tx_start && !tx_ready) begin
          bad++;
          $display("FAIL tx_start_while_not_ready: tx_ready=%0b", tx_ready);
        end
        if (tx_start && prev_start) begin
          bad++;
          $display("FAIL tx_start_width: high %0d consecutive cycles, expected 1", 2);
        end
        if (tx_start && hr_busy) begin
          bad++;
          $display("FAIL tx_during_busy: hr_busy=%0b, expected 0", hr_busy);
        end
        if (hr_wr_req && hr_rd_req) begin
          bad++;
          $display("FAIL req_overlap: wr=%0b rd=%0b, expected not both", hr_wr_req, hr_rd_req);
        end
      end
      prev_start = tx_start;
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rcv = 1'b1;
    rx_data = b;
    @(negedge clk);
    rcv = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] op);
    send_byte(cmd);
    for (int i = 3; i >= 0; i--) send_byte(op[8*i +: 8]);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d bytes still pending after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    total++;
    if ({tx_start, tx_data, hr_addr, hr_wr_d, hr_wr_req, hr_rd_req, err_overrun, err_timeout} !== '0) begin
      bad++;
      $display("FAIL %s: start=%0b data=%02h addr=%08h wd=%08h wr=%0b rd=%0b ovr=%0b to=%0b, expected all 0",
               tag, tx_start, tx_data, hr_addr, hr_wr_d, hr_wr_req, hr_rd_req, err_overrun, err_timeout);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_outputs");
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("after_reset_release");
  endtask

  task automatic test_addr();
    push_word(32'h0000_1000);
    send_frame(8'h01, 32'h0000_1000);
    drain(1000);
    total++;
    if (hr_addr !== 32'h0000_1000) begin
      bad++;
      $display("FAIL addr: hr_addr=%08h, expected 00001000", hr_addr);
    end
  endtask

  task automatic test_write();
    push_word(32'hCAFE_BABE);
    send_frame(8'h02, 32'hCAFE_BABE);
    drain(1000);
    total++;
    if (hr_wr_d !== 32'hCAFE_BABE) begin
      bad++;
      $display("FAIL load: hr_wr_d=%08h, expected cafebabe", hr_wr_d);
    end
    push_word(32'h0000_0003);
    send_frame(8'h03, 32'h0);
    drain(1000);
    total++;
    if (wr_pulses !== 1 || rd_pulses !== 0) begin
      bad++;
      $display("FAIL write_pulses: wr=%0d rd=%0d, expected wr=1 rd=0", wr_pulses, rd_pulses);
    end
  endtask

  task automatic test_read();
    rd_en = 1'b1;
    rd_delay = 30;
    rd_val = 32'h1234_5678;
    push_word(32'h1234_5678);
    send_frame(8'h05, 32'hA5A5_A5A5);
    drain(1000);
    push_word(32'h1234_5678);
    send_frame(8'h04, 32'h0);
    drain(1000);
    total++;
    if (rd_pulses !== 1) begin
      bad++;
      $display("FAIL read_pulses: rd=%0d, expected 1", rd_pulses);
    end
  endtask

  task automatic test_timeout();
    total++;
    if (err_timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_pre: err_timeout=%0b, expected 0", err_timeout);
    end
    rd_en = 1'b0;
    push_word(32'hDEAD_BEEF);
    send_frame(8'h05, 32'h0);
    drain(2000);
    total++;
    if (err_timeout !== 1'b1) begin
      bad++;
      $display("FAIL timeout_flag: err_timeout=%0b, expected 1", err_timeout);
    end
    push_word(32'h1234_5678);
    send_frame(8'h04, 32'h0);
    drain(1000);
  endtask

  task automatic test_count_and_rx_timeout();
    for (int i = 0; i < 3; i++) begin
      push_word(32'(i));
      send_frame(8'h06, 32'h0);
      drain(1000);
    end
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    repeat (RXT + 1) @(negedge clk);
    push_word(32'h0000_0103);
    send_frame(8'h07, 32'h0);
    drain(1000);
  endtask

  task automatic test_overrun();
    total++;
    if (err_overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_pre: err_overrun=%0b, expected 0", err_overrun);
    end
    push_word(32'h0000_0103);
    send_frame(8'h07, 32'h0);
    repeat (5) @(negedge clk);
    send_byte(8'h55);
    drain(1000);
    total++;
    if (err_overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_flag: err_overrun=%0b, expected 1", err_overrun);
    end
    push_word(32'h0000_0003);
    send_frame(8'h06, 32'h0);
    drain(1000);
  endtask

  task automatic test_reset_mid();
    int rd_before;
    rd_en = 1'b0;
    rd_before = rd_pulses;
    send_frame(8'h05, 32'h0);
    repeat (15) @(negedge clk);
    total++;
    if (rd_pulses !== rd_before + 1) begin
      bad++;
      $display("FAIL mid_req: rd pulses=%0d, expected %0d", rd_pulses, rd_before + 1);
    end
    rstn = 1'b0;
    #1;
    check_idle_outputs("reset_mid_outputs");
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_outputs("post_reset_quiet");
    end
    push_word(32'h0000_0000);
    send_frame(8'h06, 32'h0);
    drain(1000);
    push_word(32'hFFFF_FFFF);
    send_frame(8'h3C, 32'h0);
    drain(1000);
  endtask

  initial begin
    test_reset();
    test_addr();
    test_write();
    test_read();
    test_timeout();
    test_count_and_rx_timeout();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
